// File: rtl/lif_tdm_scheduler.sv
// lif_tdm_scheduler: time-multiplexed leak/integrate/fire sweep over a feed-forward neuron chain.
module lif_tdm_scheduler #(
    parameter int N_NEURONS  = 4,
    parameter int CUR_W      = 5,
    parameter int STATE_W    = 8,
    parameter int THRESHOLD  = 48,
    parameter int LEAK_SHIFT = 1,
    parameter int W_SYN      = 20,
    parameter int REFRACT    = 2,
    localparam int IW = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1,
    localparam int RW = (REFRACT > 0) ? $clog2(REFRACT + 1) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       tick_valid,
    output logic                       tick_ready,
    input  logic [N_NEURONS*CUR_W-1:0] current,
    output logic                       busy,
    output logic                       done,
    output logic [N_NEURONS-1:0]       spikes,
    input  logic [IW-1:0]              obs_sel,
    output logic [STATE_W-1:0]         obs_state
);
    typedef enum logic [1:0] {IDLE, LOAD, UPDATE, DONE} fsm_e;
    fsm_e                       fsm_q;
    logic [IW-1:0]              idx_q;
    logic                       prev_q;
    logic                       done_q;
    logic [N_NEURONS-1:0]       acc_q;
    logic [N_NEURONS-1:0]       spikes_q;
    logic [N_NEURONS*CUR_W-1:0] shadow_q;
    logic [STATE_W-1:0]         mem_q [N_NEURONS];
    logic [RW-1:0]              ref_q [N_NEURONS];
    logic [STATE_W-1:0]         obs_q;
    logic [CUR_W-1:0]           cur;
    logic [STATE_W:0]           sum;
    logic                       held;
    logic                       spike_d;
    logic [STATE_W-1:0]         mem_d;
    logic [RW-1:0]              ref_d;
    // The single shared adder/comparator, steered by idx_q
    always_comb begin
        cur     = shadow_q[idx_q*CUR_W +: CUR_W];
        held    = ref_q[idx_q] != '0;
        sum     = (STATE_W+1)'(mem_q[idx_q] >> LEAK_SHIFT) + (STATE_W+1)'(cur)
                + (prev_q ? (STATE_W+1)'(W_SYN) : '0);
        spike_d = !held && sum >= (STATE_W+1)'(THRESHOLD);
        mem_d   = (held || spike_d) ? '0 : sum[STATE_W-1:0];
        ref_d   = held ? ref_q[idx_q] - 1'b1 : spike_d ? RW'(REFRACT) : '0;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q    <= IDLE;
            idx_q    <= '0;
            prev_q   <= 1'b0;
            done_q   <= 1'b0;
            acc_q    <= '0;
            spikes_q <= '0;
            shadow_q <= '0;
            obs_q    <= '0;
            for (int i = 0; i < N_NEURONS; i++) begin
                mem_q[i] <= '0;
                ref_q[i] <= '0;
            end
        end else begin
            obs_q  <= mem_q[obs_sel];
            done_q <= 1'b0;
            case (fsm_q)
                IDLE: if (tick_valid) begin
                    shadow_q <= current;
                    fsm_q    <= LOAD;
                end
                LOAD: begin
                    idx_q  <= '0;
                    prev_q <= 1'b0;
                    acc_q  <= '0;
                    fsm_q  <= UPDATE;
                end
                UPDATE: begin
                    mem_q[idx_q] <= mem_d;
                    ref_q[idx_q] <= ref_d;
                    acc_q[idx_q] <= spike_d;
                    prev_q       <= spike_d;
                    idx_q        <= idx_q + 1'b1;
                    // Last neuron: publish the vector so it is valid alongside the done pulse
                    if (idx_q == IW'(N_NEURONS - 1)) begin
                        spikes_q <= {spike_d, acc_q[N_NEURONS-2:0]};
                        done_q   <= 1'b1;
                        fsm_q    <= DONE;
                    end
                end
                default: fsm_q <= IDLE;
            endcase
        end
    end
    assign tick_ready = fsm_q == IDLE;
    assign busy       = fsm_q != IDLE;
    assign done       = done_q;
    assign spikes     = spikes_q;
    assign obs_state  = obs_q;
endmodule

// File: tb/tb_lif_tdm_scheduler.sv
// tb_lif_tdm_scheduler: directed checks of sweep timing, LIF arithmetic, chaining and reset.
module tb_lif_tdm_scheduler;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tick_valid = 1'b0;
    logic        tick_ready;
    logic [19:0] current = '0;
    logic        busy;
    logic        done;
    logic [3:0]  spikes;
    logic [1:0]  obs_sel = '0;
    logic [7:0]  obs_state;
    int          n_chk = 0;
    int          n_bad = 0;
    logic [3:0]  sp;
    logic [7:0]  v;
    localparam logic [19:0] BASE = 20'd31;

    lif_tdm_scheduler dut (
        .clk(clk), .rst_n(rst_n), .tick_valid(tick_valid), .tick_ready(tick_ready),
        .current(current), .busy(busy), .done(done), .spikes(spikes),
        .obs_sel(obs_sel), .obs_state(obs_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        tick_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic run_tick(input logic [19:0] cur, output logic [3:0] s);
        int n;
        current = cur;
        tick_valid = 1'b1;
        n = 0;
        while (!tick_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ready", int'(tick_ready), 1);
        @(negedge clk);
        tick_valid = 1'b0;
        n = 1;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("latency", n, 6);
        s = spikes;
        @(negedge clk);
    endtask

    task automatic peek(input int k, output logic [7:0] r);
        obs_sel = 2'(k);
        @(negedge clk);
        r = obs_state;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        // 1: reset values
        do_reset();
        chk("rst_spikes", int'(spikes), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ready", int'(tick_ready), 1);
        for (int k = 0; k < 4; k++) begin
            peek(k, v);
            chk("rst_obs", int'(v), 0);
        end
        // 2: cycle-accurate sweep timing
        current = '0;
        tick_valid = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            tick_valid = 1'b0;
            chk("t_done", int'(done), int'(i == 6));
            chk("t_busy", int'(busy), int'(i < 7));
            chk("t_ready", int'(tick_ready), int'(i == 7));
        end
        chk("t_spikes", int'(spikes), 0);
        // 3: leak, fire, refractory on neuron 0
        run_tick(BASE, sp); peek(0, v);
        chk("s3_t1_st", int'(v), 31); chk("s3_t1_sp", int'(sp), 0);
        run_tick(BASE, sp); peek(0, v);
        chk("s3_t2_st", int'(v), 46); chk("s3_t2_sp", int'(sp), 0);
        run_tick(BASE, sp); peek(0, v);
        chk("s3_t3_st", int'(v), 0); chk("s3_t3_sp", int'(sp), 1);
        peek(1, v); chk("s3_t3_n1", int'(v), 20);
        run_tick(BASE, sp); peek(0, v);
        chk("s3_t4_st", int'(v), 0); chk("s3_t4_sp", int'(sp), 0);
        peek(1, v); chk("s3_t4_n1", int'(v), 10);
        run_tick(BASE, sp); peek(0, v);
        chk("s3_t5_st", int'(v), 0); chk("s3_t5_sp", int'(sp), 0);
        run_tick(BASE, sp); peek(0, v);
        chk("s3_t6_st", int'(v), 31); chk("s3_t6_sp", int'(sp), 0);
        // 4: cascade, neuron1 current 20
        do_reset();
        run_tick({10'd0, 5'd20, 5'd31}, sp); peek(1, v);
        chk("s4_t1_n1", int'(v), 20); chk("s4_t1_sp", int'(sp), 0);
        run_tick({10'd0, 5'd20, 5'd31}, sp); peek(1, v);
        chk("s4_t2_n1", int'(v), 30);
        run_tick({10'd0, 5'd20, 5'd31}, sp);
        chk("s4_t3_sp", int'(sp), 3);
        peek(1, v); chk("s4_t3_n1", int'(v), 0);
        peek(2, v); chk("s4_t3_n2", int'(v), 20);
        // 5: tick_valid held, currents disturbed mid-sweep
        do_reset();
        current = BASE;
        tick_valid = 1'b1;
        for (int i = 1; i <= 21; i++) begin
            @(negedge clk);
            chk("b2b_done", int'(done), int'((i % 7) == 6));
            chk("b2b_busy", int'(busy), int'((i % 7) != 0));
            current = (busy && !done) ? 20'hFFFFF : BASE;
        end
        tick_valid = 1'b0;
        @(negedge clk);
        chk("b2b_sp", int'(spikes), 1);
        peek(0, v); chk("b2b_n0", int'(v), 0);
        peek(1, v); chk("b2b_n1", int'(v), 20);
        peek(3, v); chk("b2b_n3", int'(v), 0);
        // 6: reset during UPDATE idx=2
        current = BASE;
        tick_valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            tick_valid = 1'b0;
        end
        obs_sel = 2'd1;
        rst_n = 1'b0;
        #1;
        chk("mid_spikes", int'(spikes), 0);
        chk("mid_busy", int'(busy), 0);
        chk("mid_done", int'(done), 0);
        chk("mid_obs", int'(obs_state), 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mid_nodone", int'(done), 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            peek(k, v);
            chk("mid_obs_k", int'(v), 0);
        end
        run_tick(BASE, sp); peek(0, v);
        chk("post_st", int'(v), 31); chk("post_sp", int'(sp), 0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
